// File: rtl/adder_result_reg.sv
// One-entry output register behind adder_4_bits: captures sum/cout over valid/ready,
// derives N/Z/C/V status flags and keeps debug transaction and carry counters.
module adder_result_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] carry_count
);

  // state | meaning
  // EMPTY | no result held, out_valid=0
  // FULL  | result and flags held, out_valid=1
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state, state_nxt;
  logic   capture;

  // A full register can still accept when the consumer drains it in the same cycle.
  assign in_ready  = !clear && ((state == EMPTY) || out_ready);
  assign capture   = in_valid && in_ready;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear)                           state_nxt = EMPTY;
    else if (capture)                    state_nxt = FULL;
    else if (state == FULL && out_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (capture) begin
      result <= sum;
      flag_n <= sum[WIDTH-1];
      flag_z <= (sum == '0);
      flag_c <= cout;
      // Overflow: operands share a sign that the sum does not.
      flag_v <= (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count   <= '0;
      carry_count <= '0;
    end else if (clear) begin
      txn_count   <= '0;
      carry_count <= '0;
    end else if (capture) begin
      txn_count <= txn_count + CNT_ONE;
      if (cout && carry_count != CNT_MAX) carry_count <= carry_count + CNT_ONE;
    end
  end

endmodule
